// File: rtl/mc_control_unit.sv
// Multi-cycle control FSM for the RV32I-subset computer: sequences IF/ID/EXE/MEM/WB
// over a shared memory port and drives datapath selects, ALU controls and write enables.
module mc_control_unit #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic [6:0]       opcode,
    input  logic [2:0]       funct3,
    input  logic             funct7_5,
    input  logic             z,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             iord,
    output logic             wir,
    output logic             wpc,
    output logic             wreg,
    output logic             wmem,
    output logic             m2reg,
    output logic             jal,
    output logic             aluimm,
    output logic [3:0]       aluc,
    output logic             sext,
    output logic             i_lui,
    output logic             i_sw,
    output logic             shift,
    output logic [1:0]       pcsource,
    output logic [2:0]       state,
    output logic             illegal,
    output logic [CNT_W-1:0] instret
);

    typedef enum logic [2:0] {
        S_IF  = 3'd0,
        S_ID  = 3'd1,
        S_EXE = 3'd2,
        S_MEM = 3'd3,
        S_WB  = 3'd4
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] instret_q;
    logic             retire;

    logic is_r, is_i, is_ld, is_st, is_br, is_lui, is_jal, is_jalr;
    logic br_ok, legal, shift_op, dec_en;

    assign is_r     = (opcode == 7'b0110011);
    assign is_i     = (opcode == 7'b0010011);
    assign is_ld    = (opcode == 7'b0000011);
    assign is_st    = (opcode == 7'b0100011);
    assign is_br    = (opcode == 7'b1100011);
    assign is_lui   = (opcode == 7'b0110111);
    assign is_jal   = (opcode == 7'b1101111);
    assign is_jalr  = (opcode == 7'b1100111);
    assign br_ok    = (funct3 == 3'b000) || (funct3 == 3'b001);
    assign legal    = is_r | is_i | is_ld | is_st | (is_br & br_ok) | is_lui | is_jal | is_jalr;
    assign shift_op = is_i & ((funct3 == 3'b001) || (funct3 == 3'b101));

    // Decode-derived selects are blanked in IF (IR not yet loaded) and for illegal encodings.
    assign dec_en = legal && (state_q == S_ID || state_q == S_EXE ||
                              state_q == S_MEM || state_q == S_WB);

    always_comb begin
        state_d  = S_IF;
        mem_req  = 1'b0;
        iord     = 1'b0;
        wir      = 1'b0;
        wpc      = 1'b0;
        wreg     = 1'b0;
        wmem     = 1'b0;
        m2reg    = 1'b0;
        jal      = 1'b0;
        aluimm   = 1'b0;
        aluc     = '0;
        sext     = 1'b0;
        i_lui    = 1'b0;
        i_sw     = 1'b0;
        shift    = 1'b0;
        pcsource = 2'b00;
        illegal  = 1'b0;

        if (dec_en) begin
            i_lui  = is_lui;
            i_sw   = is_st;
            shift  = shift_op;
            sext   = is_i | is_ld | is_jalr | is_br;
            aluimm = is_i | is_ld | is_st | is_jalr;
            if (is_br)        pcsource = 2'b01;
            else if (is_jalr) pcsource = 2'b10;
            else if (is_jal)  pcsource = 2'b11;
            if (is_r || shift_op) aluc = {funct7_5, funct3};
            else if (is_i)        aluc = {1'b0, funct3};
            else if (is_br)       aluc = 4'b1000;
        end

        case (state_q)
            S_IF: begin
                mem_req = 1'b1;
                if (mem_ready) begin
                    wir     = 1'b1;
                    wpc     = 1'b1;
                    state_d = S_ID;
                end else begin
                    state_d = S_IF;
                end
            end
            S_ID: begin
                if (!legal)                state_d = S_IF;
                else if (is_lui || is_jal) state_d = S_WB;
                else                       state_d = S_EXE;
                illegal = ~legal;
            end
            S_EXE: begin
                if (is_br) begin
                    wpc     = ((funct3 == 3'b000) & z) | ((funct3 == 3'b001) & ~z);
                    state_d = S_IF;
                end else if (is_ld || is_st) begin
                    state_d = S_MEM;
                end else begin
                    state_d = S_WB;
                end
            end
            S_MEM: begin
                mem_req = 1'b1;
                iord    = 1'b1;
                wmem    = is_st;
                if (mem_ready) state_d = is_st ? S_IF : S_WB;
                else           state_d = S_MEM;
            end
            S_WB: begin
                wreg    = 1'b1;
                m2reg   = is_ld;
                jal     = is_jal | is_jalr;
                wpc     = is_jal | is_jalr;
                state_d = S_IF;
            end
            default: state_d = S_IF;
        endcase

        // Reset overrides every control output, including the memory request.
        if (!resetn) begin
            mem_req  = 1'b0;
            iord     = 1'b0;
            wir      = 1'b0;
            wpc      = 1'b0;
            wreg     = 1'b0;
            wmem     = 1'b0;
            m2reg    = 1'b0;
            jal      = 1'b0;
            aluimm   = 1'b0;
            aluc     = '0;
            sext     = 1'b0;
            i_lui    = 1'b0;
            i_sw     = 1'b0;
            shift    = 1'b0;
            pcsource = 2'b00;
            illegal  = 1'b0;
        end
    end

    assign retire = (state_d == S_IF) &&
                    (state_q == S_EXE || state_q == S_MEM || state_q == S_WB);

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q   <= S_IF;
            instret_q <= '0;
        end else begin
            state_q <= state_d;
            if (retire) instret_q <= instret_q + CNT_W'(1);
        end
    end

    assign state   = resetn ? state_q : 3'd0;
    assign instret = instret_q;

endmodule

// File: doc/mc_control_unit.md
# mc_control_unit

Multi-cycle control FSM for the RV32I-subset computer. It sequences fetch, decode, execute, memory and writeback over a shared instruction/data memory port. It drives the immediate extender's select lines (`sext`, `i_lui`, `i_sw`, `shift`, `pcsource`), the ALU controls and the register/PC/IR/memory write enables. It sits beside the datapath and receives the opcode fields from the instruction register.

## Interface
Parameters:
- `CNT_W`, 32, width of the retired-instruction counter.

Ports:
- `clock`, in, 1, single clock, rising edge.
- `resetn`, in, 1, asynchronous active-low reset.
- `opcode`, in, 7, IR[6:0].
- `funct3`, in, 3, IR[14:12].
- `funct7_5`, in, 1, IR[30].
- `z`, in, 1, ALU zero flag, valid in EXE.
- `mem_ready`, in, 1, memory handshake completion.
- `mem_req`, out, 1, memory access request; held until `mem_ready`.
- `iord`, out, 1, address select: 0 = PC, 1 = ALU result.
- `wir`, `wpc`, `wreg`, `wmem`, out, 1 each, write enables.
- `m2reg`, `jal`, `aluimm`, out, 1 each, writeback-from-memory, link (pc+4) writeback, ALU B = immediate.
- `aluc`, out, 4, ALU op.
- `sext`, `i_lui`, `i_sw`, `shift`, out, 1 each, immediate-extender selects.
- `pcsource`, out, 2, 00 pc+4, 01 branch, 10 jalr, 11 jal.
- `state`, out, 3, current state, for debug.
- `illegal`, out, 1, one-cycle pulse on an unsupported opcode.
- `instret`, out, `CNT_W`, count of retired instructions.

## Operation
- States: IF=0, ID=1, EXE=2, MEM=3, WB=4. The encodings 5–7 go to IF on the next clock.
- Supported classes: R (0110011), I-ALU (0010011), LOAD (0000011), STORE (0100011), BRANCH (1100011, beq/bne only), LUI (0110111), JAL (1101111), JALR (1100111).

Per-state behaviour:
- **IF:** `mem_req`=1, `iord`=0. The FSM stays in IF while `mem_ready`=0. On `mem_ready`=1 it pulses `wir`=1 and `wpc`=1 (`pcsource`=00), then goes to ID.
- **ID:**
  - LUI: go to WB.
  - JAL: go to WB.
  - Any other supported opcode: go to EXE.
  - Unsupported opcode: pulse `illegal`, make no writes, go to IF, do not count the instruction.
- **EXE:**
  - R, I-ALU, JALR: go to WB.
  - LOAD, STORE: go to MEM.
  - BRANCH: `wpc` = (funct3==000 & z) | (funct3==001 & ~z), then go to IF. Any other branch funct3 is illegal and is detected in ID.
- **MEM:** `mem_req`=1, `iord`=1, and `wmem`=1 for STORE. On `mem_ready`, a STORE goes to IF and a LOAD goes to WB. Otherwise the FSM holds in MEM.
- **WB:** `wreg`=1, then go to IF.
  - LOAD: `m2reg`=1.
  - JAL/JALR: `jal`=1 and `wpc`=1.

Decode-derived outputs:
- Held at 0 in IF.
- Valid and constant from ID through the last state of the instruction, because IR is stable.
- `pcsource`: 01 for BRANCH and 11 for JAL, set from ID so the extender selects the correct offset. 10 for JALR. 00 otherwise.
- `i_lui` = LUI.
- `i_sw` = STORE.
- `shift` = I-ALU & funct3 ∈ {001, 101}.
- `sext` = 1 for I-ALU, LOAD, JALR and BRANCH; 0 otherwise.
- `aluimm` = 1 for I-ALU, LOAD, STORE and JALR.

`aluc` rules:
- R: {funct7_5, funct3}.
- I-ALU shift: {funct7_5, funct3}.
- I-ALU non-shift: {0, funct3}.
- BRANCH: 1000 (sub).
- LOAD/STORE/JALR/LUI/JAL: 0000.

Counters and reset:
- `instret` increments by 1 on every transition into IF from EXE, MEM or WB. It wraps modulo 2^`CNT_W`.
- Reset: `state`=IF and `instret`=0. While `resetn`=0, every output is forced to 0, including `mem_req`.
- Mid-operation reset abandons the instruction with no write pulses. Fetch restarts on the first clock after `resetn` rises.

## Timing
- All state and `instret` updates happen on the rising edge of `clock`. Control outputs are combinational from state plus decode inputs.
- Write enables are single-cycle, except `wmem`/`mem_req`, which are held until `mem_ready`.
- Cycles with zero-wait memory (`mem_ready` high on the request cycle):

| Class | Cycles | Path |
|---|---|---|
| BRANCH | 3 | IF, ID, EXE |
| LUI, JAL | 3 | IF, ID, WB |
| R, I-ALU, JALR | 4 | IF, ID, EXE, WB |
| STORE | 4 | IF, ID, EXE, MEM |
| LOAD | 5 | IF, ID, EXE, MEM, WB |

- Each memory wait cycle adds exactly 1 cycle in IF or MEM.
- `mem_ready` is ignored outside IF and MEM.
- `z` is sampled only in EXE.
- `illegal` and `instret` never change in the same cycle.

## Test plan
- **Reset:** assert `resetn`=0 mid-MEM of a STORE with `mem_ready`=0 → all outputs 0, `state`=0, `instret`=0; after release, `mem_req`=1 and `iord`=0 in the first cycle.
- **Zero-wait ALU stream:** run `addi` (opcode 0010011, f3 000), then `add`, then `lui` → state sequences 0,1,2,4 / 0,1,2,4 / 0,1,4; `instret`=3 after 11 cycles. The `addi` has `sext`=1 and `aluimm`=1; the `lui` has `i_lui`=1.
- **LOAD with 2 wait cycles in MEM:** → MEM held for 3 cycles with `iord`=1 and `wmem`=0; then WB with `wreg`=1 and `m2reg`=1; total 7 cycles.
- **beq:**
  - `z`=1 → `pcsource`=01 from ID and `wpc`=1 in EXE.
  - `z`=0 → `wpc`=0 and `pcsource` still 01.
  - bne with `z`=0 → `wpc`=1.
- **JAL, then JALR:** JAL → `pcsource`=11 from ID and `wreg`=`wpc`=`jal`=1 in WB. JALR (`pcsource`=10) → `wreg`=`wpc`=`jal`=1 in WB with `sext`=1 and `aluimm`=1.
- **Illegal and wrap:**
  - Opcode 1110011 → `illegal` pulses in ID, no writes, next state IF, `instret` unchanged.
  - With `CNT_W`=4 and 16 retired instructions → `instret` wraps to 0.
